// File: rtl/event_encoder8_pkg.sv
// Shared types, sizes and helpers for the 8-line event encoder.
package event_enc_pkg;

    localparam int ENC_N = 8;
    localparam int ENC_W = 3;

    typedef enum logic {ST_IDLE, ST_HOLD} enc_state_t;

    // One-hot mask with only bit idx set.
    function automatic logic [ENC_N-1:0] onehot_of(input logic [ENC_W-1:0] idx);
        return ENC_N'(1) << idx;
    endfunction

endpackage

// File: rtl/event_encoder8_if.sv
// Output handshake bundle of the event encoder: code with valid/ready.
interface event_encoder8_if;
    import event_enc_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [ENC_W-1:0] code;

    modport master (output out_valid, output code, input out_ready);
    modport slave  (input out_valid, input code, output out_ready);

endinterface

// File: rtl/event_encoder8_prio_sel.sv
// Combinational priority selector: finds the first set bit of mask,
// searching upward from index start and wrapping modulo ENC_N.
module enc_prio_sel
    import event_enc_pkg::*;
(
    input  logic [ENC_N-1:0] mask,
    input  logic [ENC_W-1:0] start,
    output logic             any,
    output logic [ENC_W-1:0] idx
);

    logic             found;
    logic [ENC_W-1:0] pos;

    // Walk the lines in search order; the first set one wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < ENC_N; k++) begin
            pos = start + ENC_W'(k);
            if (!found && mask[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/event_encoder8.sv
// event_encoder8: captures one-hot event pulses into a pending register and
// drains them one binary code per valid/ready transfer.
// Optional macro ROUND_ROBIN_EN selects rotating priority; undefined gives
// fixed lowest-index-first priority.
module event_encoder8
    import event_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ENC_N-1:0]  req,
    output logic [ENC_N-1:0]  pending,
    output logic              overflow,
    event_encoder8_if.master  out_if
);

    enc_state_t       state_q;
    logic             valid_q;
    logic [ENC_W-1:0] code_q;
    logic [ENC_N-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;

    logic             sel_any;
    logic [ENC_W-1:0] sel_idx;
    logic [ENC_W-1:0] sel_start;
    logic             load;
    logic [ENC_N-1:0] load_mask;

`ifdef ROUND_ROBIN_EN
    logic [ENC_W-1:0] rr_ptr_q;

    // Remember the last loaded index so the next search starts just past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= ENC_W'(ENC_N - 1);
        end else if (load) begin
            rr_ptr_q <= sel_idx;
        end
    end

    assign sel_start = rr_ptr_q + ENC_W'(1);
`else
    assign sel_start = '0;
`endif

    enc_prio_sel u_sel (
        .mask  (pending_q),
        .start (sel_start),
        .any   (sel_any),
        .idx   (sel_idx)
    );

    // The output stage can take a new code when empty or when the current one
    // is being accepted; only the registered pending value is eligible.
    assign load      = en && sel_any && ((state_q == ST_IDLE) || out_if.out_ready);
    assign load_mask = load ? onehot_of(sel_idx) : '0;

    // Next pending/overflow: a new req on a bit being loaded is not a loss.
    always_comb begin
        pending_d  = '0;
        overflow_d = overflow_q;
        if (en) begin
            pending_d  = (pending_q & ~load_mask) | req;
            overflow_d = overflow_q | (|(req & pending_q & ~load_mask));
        end
    end

    // Pending register and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Output FSM: load into the code register, hold until accepted, chain
    // back-to-back transfers while events remain; en=0 flushes but keeps code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else if (!en) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        code_q  <= sel_idx;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_if.out_ready) begin
                        if (load) begin
                            code_q <= sel_idx;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.code      = code_q;
    assign pending          = pending_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_event_encoder8.sv
// Self-checking bench for event_encoder8: reference model plus directed
// vectors with hand-computed expectations. Honours ROUND_ROBIN_EN.
module tb_event_encoder8;
    import event_enc_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [7:0] req   = 8'h00;
    logic [7:0] pending;
    logic       overflow;

    int n_chk  = 0;
    int n_fail = 0;

    event_encoder8_if bus ();

    event_encoder8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .pending  (pending),
        .overflow (overflow),
        .out_if   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_pend;
    logic       m_v;
    logic [2:0] m_code;
    logic       m_ovf;
    logic [2:0] m_rr;

    function automatic int pick(input logic [7:0] m, input int start);
        for (int k = 0; k < 8; k++)
            if (m[(start + k) % 8]) return (start + k) % 8;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        int         idx;
        int         st;
        logic [7:0] ldm;
        if (!rst_n) begin
            m_pend = 8'h00; m_v = 1'b0; m_code = 3'd0; m_ovf = 1'b0; m_rr = 3'd7;
        end else if (!en) begin
            m_pend = 8'h00; m_v = 1'b0;
        end else begin
            ldm = 8'h00;
`ifdef ROUND_ROBIN_EN
            st = (int'(m_rr) + 1) % 8;
`else
            st = 0;
`endif
            if (!m_v || bus.out_ready) begin
                idx = pick(m_pend, st);
                if (idx >= 0) begin
                    ldm    = 8'(1) << idx;
                    m_code = 3'(idx);
                    m_rr   = 3'(idx);
                    m_v    = 1'b1;
                end else begin
                    m_v = 1'b0;
                end
            end
            if ((req & m_pend & ~ldm) != 8'h00) m_ovf = 1'b1;
            m_pend = (m_pend & ~ldm) | req;
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("mdl_valid",    32'(bus.out_valid), 32'(m_v));
            check("mdl_code",     32'(bus.code),      32'(m_code));
            check("mdl_pending",  32'(pending),       32'(m_pend));
            check("mdl_overflow", 32'(overflow),      32'(m_ovf));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_valid", 32'(bus.out_valid), 32'd0);
            check("rst_code",  32'(bus.code),      32'd0);
            check("rst_pend",  32'(pending),       32'd0);
            check("rst_ovf",   32'(overflow),      32'd0);
        end

        // 2: single pulse on line 5
        bus.out_ready = 1'b1;
        req = 8'h20; step(); req = 8'h00;
        check("p5_pend_t1",  32'(pending),       32'h20);
        check("p5_valid_t1", 32'(bus.out_valid), 32'd0);
        step();
        check("p5_valid_t2", 32'(bus.out_valid), 32'd1);
        check("p5_code_t2",  32'(bus.code),      32'd5);
        check("p5_pend_t2",  32'(pending),       32'h00);
        step();
        check("p5_valid_t3", 32'(bus.out_valid), 32'd0);

        // 3: two lines at once, back-to-back drain
        req = 8'h81; step(); req = 8'h00;
        check("p81_pend", 32'(pending), 32'h81);
        step();
        check("p81_v1", 32'(bus.out_valid), 32'd1);
`ifdef ROUND_ROBIN_EN
        check("p81_c1", 32'(bus.code), 32'd7);
`else
        check("p81_c1", 32'(bus.code), 32'd0);
`endif
        step();
        check("p81_v2", 32'(bus.out_valid), 32'd1);
`ifdef ROUND_ROBIN_EN
        check("p81_c2", 32'(bus.code), 32'd0);
`else
        check("p81_c2", 32'(bus.code), 32'd7);
`endif
        step();
        check("p81_v3", 32'(bus.out_valid), 32'd0);

        // three events drained at one per cycle
        req = 8'h16; step(); req = 8'h00;
        step(); check("p16_c1", 32'(bus.code), 32'd1);
        step(); check("p16_c2", 32'(bus.code), 32'd2);
        step(); check("p16_c3", 32'(bus.code), 32'd4);
        check("p16_v3", 32'(bus.out_valid), 32'd1);
        step(); check("p16_v4", 32'(bus.out_valid), 32'd0);

        // 4: stalled consumer holding code 3, repeated pulses on line 3
        bus.out_ready = 1'b0;
        req = 8'h08; step(); req = 8'h00;
        step();
        check("h3_code", 32'(bus.code), 32'd3);
        req = 8'h08; step(); req = 8'h00;
        check("h3_pend1", 32'(pending),  32'h08);
        check("h3_ovf1",  32'(overflow), 32'd0);
        step();
        req = 8'h08; step(); req = 8'h00;
        check("h3_ovf2",  32'(overflow), 32'd1);
        check("h3_code2", 32'(bus.code), 32'd3);
        req = 8'h04; step(); req = 8'h00;
        check("h3_pend2", 32'(pending),  32'h0C);
        check("h3_valid", 32'(bus.out_valid), 32'd1);

        // 5: one-cycle flush
        en = 1'b0; step(); en = 1'b1;
        check("fl_valid", 32'(bus.out_valid), 32'd0);
        check("fl_pend",  32'(pending),       32'h00);
        check("fl_ovf",   32'(overflow),      32'd1);
        check("fl_code",  32'(bus.code),      32'd3);
        step();
        check("fl_idle", 32'(bus.out_valid), 32'd0);

        // 6: async reset between edges during HOLD
        req = 8'h01; step(); req = 8'h00;
        step();
        check("ar_hold_v", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'd0);
        check("ar_code",  32'(bus.code),      32'd0);
        check("ar_pend",  32'(pending),       32'd0);
        check("ar_ovf",   32'(overflow),      32'd0);
        @(negedge clk); rst_n = 1'b1;

        // load and new req on the same line in one cycle: no loss, no overflow
        req = 8'h06; step(); req = 8'h00;
        step();
        check("sm_c1",   32'(bus.code), 32'd1);
        check("sm_pend", 32'(pending),  32'h04);
        bus.out_ready = 1'b1;
        req = 8'h04; step(); req = 8'h00;
        check("sm_c2",    32'(bus.code), 32'd2);
        check("sm_pend2", 32'(pending),  32'h04);
        check("sm_ovf",   32'(overflow), 32'd0);
        step();
        check("sm_c3",    32'(bus.code),      32'd2);
        check("sm_v3",    32'(bus.out_valid), 32'd1);
        check("sm_pend3", 32'(pending),       32'h00);
        step();
        check("sm_v4", 32'(bus.out_valid), 32'd0);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
